// File: rtl/counter_down_16bit_timer.sv
// Loadable down-counting timer: a reload value and prescale are accepted over a valid/ready
// handshake, then the count drops once per prescaled tick and o_tc pulses on each expiry.
module counter_down_16bit_timer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_async,
  input  logic                  i_load_valid,
  output logic                  o_load_ready,
  input  logic [WIDTH-1:0]      i_load_value,
  input  logic [PRESCALE_W-1:0] i_load_prescale,
  input  logic                  i_auto_reload,
  input  logic                  i_start,
  input  logic                  i_stop,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_busy,
  output logic                  o_tc
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2
  } state_e;

  state_e                  state_q;
  logic [WIDTH-1:0]        count_q;
  logic [WIDTH-1:0]        reload_q;
  logic [PRESCALE_W-1:0]   prescale_q;
  logic [PRESCALE_W-1:0]   psc_q;
  logic                    auto_q;
  logic                    busy_q;
  logic                    tc_q;
  logic                    load_fire;
  logic                    tick;

  // Ready is decoded straight from state so it reads 1 while reset holds the block in idle.
  assign o_load_ready = (state_q != StRun);
  assign load_fire    = i_load_valid & o_load_ready;
  assign tick         = (psc_q == prescale_q);

  always_ff @(posedge i_clk or negedge i_rst_async) begin
    if (!i_rst_async) begin
      state_q    <= StIdle;
      count_q    <= '0;
      reload_q   <= '0;
      prescale_q <= '0;
      psc_q      <= '0;
      auto_q     <= 1'b0;
      busy_q     <= 1'b0;
      tc_q       <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      case (state_q)
        StIdle, StArmed: begin
          // A load outranks a same-cycle start; the start is simply dropped.
          if (load_fire) begin
            reload_q   <= i_load_value;
            prescale_q <= i_load_prescale;
            auto_q     <= i_auto_reload;
            count_q    <= i_load_value;
            psc_q      <= '0;
            state_q    <= StArmed;
            busy_q     <= 1'b0;
          end else if ((state_q == StArmed) && i_start && !i_stop) begin
            psc_q   <= '0;
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (i_stop) begin
            // Count and prescaler hold; a tick landing on this cycle is discarded.
            state_q <= StArmed;
            busy_q  <= 1'b0;
          end else if (tick) begin
            psc_q <= '0;
            if (count_q != '0) begin
              count_q <= count_q - WIDTH'(1);
            end else begin
              tc_q <= 1'b1;
              if (auto_q) begin
                count_q <= reload_q;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end
          end else begin
            psc_q <= psc_q + PRESCALE_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_count = count_q;
  assign o_busy  = busy_q;
  assign o_tc    = tc_q;

endmodule

// File: tb/tb_counter_down_16bit_timer.sv
// Bench for the down-counting timer: directed vector table, hand-written multi-cycle
// sequences and a randomized run against an arithmetic reference model.
module tb_counter_down_16bit_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] value = '0;
  logic [7:0]  presc = '0;
  logic        auto_r = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        ready, busy, tc;
  logic [15:0] count;

  int total = 0;
  int bad   = 0;

  counter_down_16bit_timer #(.WIDTH(16), .PRESCALE_W(8)) dut (
    .i_clk           (clk),
    .i_rst_async     (rst_n),
    .i_load_valid    (valid),
    .o_load_ready    (ready),
    .i_load_value    (value),
    .i_load_prescale (presc),
    .i_auto_reload   (auto_r),
    .i_start         (start),
    .i_stop          (stop),
    .o_count         (count),
    .o_busy          (busy),
    .o_tc            (tc)
  );

  always #5 clk = ~clk;

  // Reference model: count derived from the number of ticks since the last (re)start.
  localparam int MIdle = 0, MArmed = 1, MRun = 2;
  int   m_state, m_r, m_p, m_a, m_count, m_base, m_run;
  logic m_tc;

  task automatic model_reset();
    m_state = MIdle; m_r = 0; m_p = 0; m_a = 0; m_count = 0; m_base = 0; m_run = 0;
    m_tc = 1'b0;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic v, input int val, input int p, input logic a,
                              input logic s, input logic st);
    int t, u;
    m_tc = 1'b0;
    if (m_state != MRun) begin
      if (v) begin
        m_r = val; m_p = p; m_a = a; m_count = val; m_state = MArmed;
      end else if (m_state == MArmed && s && !st) begin
        m_state = MRun; m_base = m_count; m_run = 0;
      end
    end else if (st) begin
      m_state = MArmed;
    end else begin
      m_run++;
      if (m_run % (m_p + 1) == 0) begin
        t = m_run / (m_p + 1);
        if (t <= m_base) begin
          m_count = m_base - t;
        end else begin
          u = (t - m_base - 1) % (m_r + 1);
          if (u == 0) begin
            m_tc = 1'b1;
            if (m_a != 0) m_count = m_r;
            else begin m_count = 0; m_state = MIdle; end
          end else begin
            m_count = m_r - u;
          end
        end
      end
    end
  endtask

  task automatic step(input logic v, input int val, input int p, input logic a,
                      input logic s, input logic st);
    valid = v; value = val[15:0]; presc = p[7:0]; auto_r = a; start = s; stop = st;
    @(posedge clk);
    model_update(v, val, p, a, s, st);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, count, m_count);
    check({tag, ".tc"}, tc, m_tc);
    check({tag, ".busy"}, busy, m_state == MRun);
    check({tag, ".ready"}, ready, m_state != MRun);
  endtask

  typedef struct {
    logic v; int val; int p; logic a; logic s; logic st;
    int e_cnt; logic e_tc; logic e_busy; logic e_rdy;
  } vec_t;
  vec_t tbl[19];

  initial begin
    int n, first_tc, tcs, prev, wrapped;
    model_reset();
    // Directed table: one-shot countdown, ignored start/load, collisions, R=0 auto.
    tbl[0]  = '{1, 3, 0, 0, 0, 0, 3, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 1, 0, 3, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 2, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[8]  = '{1, 5, 0, 0, 1, 0, 5, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 1, 1, 5, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 5, 0, 1, 0};
    tbl[11] = '{1, 9, 0, 0, 0, 0, 4, 0, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 1, 4, 0, 0, 1};
    tbl[13] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};

    // Reset held: ready must already be high.
    #2;
    check("rst.ready", ready, 1);
    check("rst.count", count, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle_step();
      check_model("idle");
    end

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, tbl[i].val, tbl[i].p, tbl[i].a, tbl[i].s, tbl[i].st);
      check($sformatf("vec%0d.count", i), count, tbl[i].e_cnt);
      check($sformatf("vec%0d.tc", i), tc, tbl[i].e_tc);
      check($sformatf("vec%0d.busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d.ready", i), ready, tbl[i].e_rdy);
    end

    // Periodic R=2 P=4: tc every 15 cycles, reload to 2 on each pulse.
    step(1'b1, 2, 4, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      idle_step();
      check($sformatf("per.tc@%0d", i), tc, (i % 15) == 0);
      if (tc) check("per.reload", count, 2);
    end
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Stop/resume: R=16 P=1, stop after 6 run cycles, resume, tc after 28 more.
    step(1'b1, 16, 1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) idle_step();
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("sr.stopcount", count, 13);
    for (int i = 0; i < 10; i++) begin
      idle_step();
      check("sr.hold", count, 13);
      check("sr.hold_busy", busy, 0);
    end
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    first_tc = -1;
    for (int i = 1; i <= 40; i++) begin
      idle_step();
      if (tc) begin first_tc = i; break; end
    end
    check("sr.resume_tc", first_tc, 28);
    check("sr.idle_after", busy, 0);

    // Full-range one-shot: exactly one tc after 65536 run cycles, never rising.
    step(1'b1, 16'hFFFF, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    tcs = 0; prev = count; wrapped = 0; n = 0; first_tc = -1;
    for (int i = 1; i <= 70000; i++) begin
      idle_step();
      if (int'(count) > prev) wrapped++;
      prev = count;
      if (tc) begin tcs++; first_tc = i; end
      if (!busy) begin n = i; break; end
    end
    check("ffff.tc_count", tcs, 1);
    check("ffff.tc_at", first_tc, 65536);
    check("ffff.end", n, 65536);
    check("ffff.wrap", wrapped, 0);
    check("ffff.final", count, 0);
    idle_step();
    check("ffff.stays", count, 0);

    // Reset mid-run: outputs clear without waiting for a clock edge.
    step(1'b1, 100, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle_step();
    check("mid.count_pre", count, 95);
    #2 rst_n = 1'b0;
    #1;
    check("mid.count", count, 0);
    check("mid.busy", busy, 0);
    check("mid.tc", tc, 0);
    check("mid.ready", ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 20), $urandom_range(0, 3),
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
